// File: rtl/draw_dstbuf_param.sv
// Destination-data buffer: registered VIF input stage feeding a single-clock FIFO
// with occupancy flags, over/underflow pulses and a sticky error bit.
module draw_dstbuf_param #(
   parameter int unsigned DW    = 64,
   parameter int unsigned AW    = 9,
   parameter int unsigned AE_TH = 4,
   parameter int unsigned AF_TH = 508,
   parameter int unsigned FWFT  = 0
) (
   input  logic          CLK,
   input  logic          RST_X,
   input  logic          INIT,
   input  logic [DW-1:0] VIF_RDATA,
   input  logic          VIF_DRWRDATAVLD,
   input  logic          DSTSEL,
   input  logic          BUF_RD,
   output logic [DW-1:0] DATA,
   output logic          DATAVALID,
   output logic          EMPTY,
   output logic          ALMOST_EMPTY,
   output logic          FULL,
   output logic          ALMOST_FULL,
   output logic [AW:0]   DATA_COUNT,
   output logic          BUF_OVER,
   output logic          BUF_UNDER,
   output logic          ERR_STICKY
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);
   localparam logic [AW:0] CntAe   = (AW+1)'(AE_TH);
   localparam logic [AW:0] CntAf   = (AW+1)'(AF_TH);

   logic [DW-1:0] in_data_q;
   logic          in_vld_q;
   logic          in_sel_q;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   cnt_d;
   logic          over_q;
   logic          under_q;
   logic          sticky_q;

   logic wr;
   logic full;
   logic empty;
   logic wr_ok;
   logic rd_ok;
   logic over_d;
   logic under_d;

   assign wr      = in_vld_q & in_sel_q;
   assign full    = (cnt_q == CntFull);
   assign empty   = (cnt_q == '0);
   assign wr_ok   = wr & ~full;
   assign rd_ok   = BUF_RD & ~empty;
   assign over_d  = wr & full;
   assign under_d = BUF_RD & empty;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         in_data_q <= '0;
         in_vld_q  <= 1'b0;
         in_sel_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         over_q    <= 1'b0;
         under_q   <= 1'b0;
         sticky_q  <= 1'b0;
      end else if (INIT) begin
         in_data_q <= '0;
         in_vld_q  <= 1'b0;
         in_sel_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         over_q    <= 1'b0;
         under_q   <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         in_data_q <= VIF_RDATA;
         in_vld_q  <= VIF_DRWRDATAVLD;
         in_sel_q  <= DSTSEL;
         if (wr_ok) wptr_q <= wptr_q + 1'b1;
         if (rd_ok) rptr_q <= rptr_q + 1'b1;
         cnt_q     <= cnt_d;
         over_q    <= over_d;
         under_q   <= under_d;
         sticky_q  <= sticky_q | over_d | under_d;
      end
   end

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (wr_ok && !INIT) mem[wptr_q] <= in_data_q;
   end

   if (FWFT == 0) begin : g_std
      logic [DW-1:0] rdata_q;
      logic          rvld_q;

      always_ff @(posedge CLK or negedge RST_X) begin
         if (!RST_X) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
         end else if (INIT) begin
            rvld_q  <= 1'b0;
         end else begin
            rvld_q <= rd_ok;
            if (rd_ok) rdata_q <= mem[rptr_q];
         end
      end

      assign DATA      = rdata_q;
      assign DATAVALID = rvld_q;
   end else begin : g_fwft
      // Head word is presented directly; forced to zero while empty.
      assign DATA      = empty ? '0 : mem[rptr_q];
      assign DATAVALID = ~empty;
   end

   assign EMPTY        = empty;
   assign FULL         = full;
   assign ALMOST_EMPTY = (cnt_q <= CntAe);
   assign ALMOST_FULL  = (cnt_q >= CntAf);
   assign DATA_COUNT   = cnt_q;
   assign BUF_OVER     = over_q;
   assign BUF_UNDER    = under_q;
   assign ERR_STICKY   = sticky_q;

endmodule

// File: tb/tb_draw_dstbuf_param.sv
// Bench for draw_dstbuf_param: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (default and FWFT builds).
module tb_draw_dstbuf_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_x, init, vld, sel, rd;
   logic [63:0] vdata;
   logic [63:0] data;
   logic        dv, empty, aempty, full, afull, over, under, sticky;
   logic [9:0]  cnt;

   logic        f_init, f_vld, f_sel, f_rd;
   logic [31:0] f_vdata, f_data;
   logic        f_dv, f_empty, f_ae, f_full, f_af, f_over, f_under, f_sticky;
   logic [4:0]  f_cnt;

   int total = 0;
   int bad   = 0;

   draw_dstbuf_param u_dut (
      .CLK(clk), .RST_X(rst_x), .INIT(init), .VIF_RDATA(vdata),
      .VIF_DRWRDATAVLD(vld), .DSTSEL(sel), .BUF_RD(rd), .DATA(data),
      .DATAVALID(dv), .EMPTY(empty), .ALMOST_EMPTY(aempty), .FULL(full),
      .ALMOST_FULL(afull), .DATA_COUNT(cnt), .BUF_OVER(over),
      .BUF_UNDER(under), .ERR_STICKY(sticky)
   );

   draw_dstbuf_param #(.DW(32), .AW(4), .AE_TH(4), .AF_TH(12), .FWFT(1)) u_fwft (
      .CLK(clk), .RST_X(rst_x), .INIT(f_init), .VIF_RDATA(f_vdata),
      .VIF_DRWRDATAVLD(f_vld), .DSTSEL(f_sel), .BUF_RD(f_rd), .DATA(f_data),
      .DATAVALID(f_dv), .EMPTY(f_empty), .ALMOST_EMPTY(f_ae), .FULL(f_full),
      .ALMOST_FULL(f_af), .DATA_COUNT(f_cnt), .BUF_OVER(f_over),
      .BUF_UNDER(f_under), .ERR_STICKY(f_sticky)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: the buffer is a queue of words; one-deep input pipeline.
   logic [63:0] mq[$];
   bit          m_pend;
   logic [63:0] m_pdata, m_data;
   bit          m_dv, m_over, m_under, m_sticky;
   int          mn;

   always @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         mq.delete();
         m_pend = 0; m_pdata = '0; m_data = '0;
         m_dv = 0; m_over = 0; m_under = 0; m_sticky = 0;
      end else if (init) begin
         mq.delete();
         m_pend = 0; m_dv = 0; m_over = 0; m_under = 0; m_sticky = 0;
      end else begin
         mn      = mq.size();
         m_over  = m_pend && (mn == 512);
         m_under = rd && (mn == 0);
         if (rd && mn > 0) begin
            m_data = mq.pop_front();
            m_dv   = 1;
         end else begin
            m_dv = 0;
         end
         if (m_pend && mn < 512) mq.push_back(m_pdata);
         m_sticky = m_sticky | m_over | m_under;
         m_pend   = vld && sel;
         m_pdata  = vdata;
      end
   end

   always @(negedge clk) begin
      if (rst_x) begin
         int n;
         n = mq.size();
         chk("m_data",   data,   m_data);
         chk("m_dvalid", dv,     m_dv);
         chk("m_count",  cnt,    64'(n));
         chk("m_empty",  empty,  n == 0);
         chk("m_aempty", aempty, n <= 4);
         chk("m_full",   full,   n == 512);
         chk("m_afull",  afull,  n >= 508);
         chk("m_over",   over,   m_over);
         chk("m_under",  under,  m_under);
         chk("m_sticky", sticky, m_sticky);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_n(input int n, input logic [63:0] base);
      vld = 1; sel = 1;
      for (int i = 0; i < n; i++) begin
         vdata = base + 64'(i);
         @(negedge clk);
      end
      vld = 0;
   endtask

   task automatic read1;
      rd = 1;
      @(negedge clk);
      rd = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},   data,   0);
      chk({tag, "_dv"},     dv,     0);
      chk({tag, "_cnt"},    cnt,    0);
      chk({tag, "_empty"},  empty,  1);
      chk({tag, "_aempty"}, aempty, 1);
      chk({tag, "_full"},   full,   0);
      chk({tag, "_afull"},  afull,  0);
      chk({tag, "_over"},   over,   0);
      chk({tag, "_under"},  under,  0);
      chk({tag, "_sticky"}, sticky, 0);
   endtask

   initial begin
      rst_x = 0; init = 0; vld = 0; sel = 0; rd = 0; vdata = '0;
      f_init = 0; f_vld = 0; f_sel = 0; f_rd = 0; f_vdata = '0;
      cyc(3);
      rst_x = 1;
      chk_reset_vals("rst");
      chk("f_rst_dv", f_dv, 0);
      chk("f_rst_data", f_data, 0);

      // Three words in, EMPTY falls two edges after the first input
      vld = 1; sel = 1; vdata = 64'h1;
      @(negedge clk); vdata = 64'h2;
      chk("lat_empty_e1", empty, 1);
      @(negedge clk); vdata = 64'h3;
      chk("lat_empty_e2", empty, 0);
      chk("lat_cnt_e2", cnt, 1);
      @(negedge clk); vld = 0;
      cyc(2);
      chk("three_cnt", cnt, 3);
      for (int k = 1; k <= 3; k++) begin
         read1();
         chk("rd_dv", dv, 1);
         chk("rd_data", data, 64'(k));
      end
      cyc(1);
      chk("rd_dv_drop", dv, 0);
      chk("rd_data_hold", data, 3);

      // Valid without DSTSEL is ignored
      vld = 1; sel = 0; vdata = 64'h55;
      cyc(10);
      chk("nosel_cnt", cnt, 0);
      chk("nosel_empty", empty, 1);
      vld = 0;

      // Underflow
      read1();
      chk("under_pulse", under, 1);
      chk("under_dv", dv, 0);
      chk("under_cnt", cnt, 0);
      chk("under_sticky", sticky, 1);
      cyc(1);
      chk("under_once", under, 0);
      chk("under_sticky_hold", sticky, 1);
      init = 1; @(negedge clk); init = 0;
      chk("init_sticky", sticky, 0);

      // Fill to full
      write_n(507, 64'h100); cyc(1);
      chk("cnt507", cnt, 507);
      chk("af507", afull, 0);
      write_n(1, 64'h100 + 507); cyc(1);
      chk("cnt508", cnt, 508);
      chk("af508", afull, 1);
      chk("full508", full, 0);
      write_n(4, 64'h100 + 508); cyc(1);
      chk("cnt512", cnt, 512);
      chk("full512", full, 1);
      write_n(1, 64'hDEAD); cyc(1);
      chk("ovf_pulse", over, 1);
      chk("ovf_sticky", sticky, 1);
      chk("ovf_cnt", cnt, 512);
      cyc(1);
      chk("ovf_once", over, 0);
      vld = 1; sel = 1; vdata = 64'hBEEF;
      @(negedge clk); vld = 0; rd = 1;
      @(negedge clk); rd = 0;
      chk("full_rw_cnt", cnt, 511);
      chk("full_rw_over", over, 1);
      chk("full_rw_data", data, 64'h100);

      // 1000 words streamed with concurrent reads, pointers wrap
      init = 1; @(negedge clk); init = 0;
      vld = 1; sel = 1; rd = 1;
      for (int i = 0; i < 1000; i++) begin
         vdata = 64'h2000 + 64'(i);
         @(negedge clk);
      end
      vld = 0;
      cyc(3);
      rd = 0;
      chk("stream_cnt", cnt, 0);
      chk("stream_last", data, 64'h23E7);

      // INIT at count 37 with a write in flight
      init = 1; @(negedge clk); init = 0;
      read1();
      write_n(37, 64'h3000); cyc(1);
      chk("c37_cnt", cnt, 37);
      chk("c37_sticky", sticky, 1);
      vld = 1; sel = 1; vdata = 64'h3100; init = 1;
      @(negedge clk); init = 0; vld = 0;
      chk("init_cnt", cnt, 0);
      chk("init_empty", empty, 1);
      chk("init_sticky2", sticky, 0);
      cyc(2);
      chk("init_inflight", cnt, 0);

      // Asynchronous reset mid-burst
      write_n(3, 64'h4000);
      vld = 1; sel = 1; vdata = 64'h4003;
      read1();
      #2 rst_x = 0;
      #1 chk_reset_vals("arst");
      @(negedge clk); vld = 0;
      @(negedge clk); rst_x = 1;
      write_n(1, 64'h77); cyc(1);
      read1();
      chk("post_rst_data", data, 64'h77);
      chk("post_rst_dv", dv, 1);

      // FWFT build
      f_vld = 1; f_sel = 1; f_vdata = 32'hA5;
      @(negedge clk); f_vld = 0;
      @(negedge clk);
      chk("f_dv", f_dv, 1);
      chk("f_data", f_data, 32'hA5);
      chk("f_cnt", f_cnt, 1);
      f_rd = 1; @(negedge clk); f_rd = 0;
      chk("f_empty", f_empty, 1);
      chk("f_dv_off", f_dv, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/draw_dstbuf_param.md
DRAW_DSTBUF_PARAM -- requirements
Module: draw_dstbuf_param

Interface
REQ-001 Parameter DW, default 64, data width in bits.
REQ-002 Parameter AW, default 9, address width; DEPTH = 2^AW (512).
REQ-003 Parameter AE_TH, default 4, almost-empty threshold in words.
REQ-004 Parameter AF_TH, default 508, almost-full threshold in words.
REQ-005 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 Legal parameters: 0 <= AE_TH < AF_TH <= DEPTH; other values are unsupported.
REQ-007 CLK  in  1  single clock; all state updates on rising edge.
REQ-008 RST_X  in  1  asynchronous, active-low reset.
REQ-009 INIT  in  1  synchronous clear.
REQ-010 VIF_RDATA  in  DW  VRAM read data.
REQ-011 VIF_DRWRDATAVLD  in  1  VIF_RDATA valid this cycle.
REQ-012 DSTSEL  in  1  qualifies VIF data as destination data.
REQ-013 BUF_RD  in  1  read/pop request.
REQ-014 DATA  out  DW  read data.
REQ-015 DATAVALID  out  1  DATA valid.
REQ-016 EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL  out  1 each  occupancy flags.
REQ-017 DATA_COUNT  out  AW+1  words stored, 0..DEPTH.
REQ-018 BUF_OVER, BUF_UNDER  out  1 each  one-cycle error pulses.
REQ-019 ERR_STICKY  out  1  latched OR of all BUF_OVER/BUF_UNDER pulses since reset/INIT.

Function
REQ-020 Input stage registers VIF_RDATA, VIF_DRWRDATAVLD, DSTSEL on every edge; write request wr = registered valid AND registered DSTSEL.
REQ-021 Latency: inputs sampled at edge n; word written at edge n+1; DATA_COUNT/EMPTY reflect it after edge n+1.
REQ-022 Write accepted iff wr and DATA_COUNT < DEPTH; rejected write discarded, BUF_OVER high for exactly the following cycle.
REQ-023 Read accepted iff BUF_RD and DATA_COUNT > 0; rejected read leaves state unchanged, BUF_UNDER high for exactly the following cycle.
REQ-024 Full + wr + BUF_RD same cycle: read accepted, write rejected (BUF_OVER pulses); empty + wr + BUF_RD: write accepted, read rejected (BUF_UNDER pulses).
REQ-025 Accepted read and write same cycle: DATA_COUNT unchanged, both pointers advance.
REQ-026 Read and write pointers are AW bits and wrap from DEPTH-1 to 0.
REQ-027 FWFT=0: DATA registered; accepted read at edge n updates DATA and asserts DATAVALID for the cycle after edge n only; DATA holds last value otherwise.
REQ-028 FWFT=1: DATA = head word, DATAVALID = !EMPTY, accepted BUF_RD pops head at the edge.
REQ-029 EMPTY = (count==0); FULL = (count==DEPTH); ALMOST_EMPTY = (count<=AE_TH); ALMOST_FULL = (count>=AF_TH); all decoded from the registered count, no input combinational paths.
REQ-030 INIT: synchronous clear of input stage, pointers, count, DATAVALID, BUF_OVER, BUF_UNDER, ERR_STICKY; overrides simultaneous read/write; memory contents need not be cleared.
REQ-031 DATA order is strict FIFO order of accepted writes.

Reset
REQ-032 RST_X low: all registers cleared asynchronously; DATA=0, DATAVALID=0, DATA_COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, BUF_OVER=0, BUF_UNDER=0, ERR_STICKY=0.
REQ-033 Reset mid-transfer discards all stored and in-flight words; first accepted write after release is read first.

Verification
REQ-034 Defaults, FWFT=0: write 0x1,0x2,0x3 with DSTSEL=1 -> EMPTY falls 2 edges after first input; three reads return 0x1,0x2,0x3, DATAVALID one cycle after each read.
REQ-035 VIF_DRWRDATAVLD=1 with DSTSEL=0 for 10 cycles -> DATA_COUNT stays 0, EMPTY=1.
REQ-036 Write 512 words -> ALMOST_FULL at count 508, FULL at 512; 513th write -> BUF_OVER one cycle, ERR_STICKY=1, count stays 512; simultaneous read+write at full -> count 511.
REQ-037 BUF_RD while empty -> BUF_UNDER one cycle, DATAVALID=0, count 0; write 1000 words with concurrent reads -> data order preserved across pointer wrap.
REQ-038 FWFT=1, DW=32, AW=4: write 0xA5 -> DATAVALID=1, DATA=0xA5 without BUF_RD; BUF_RD -> EMPTY=1 next cycle.
REQ-039 INIT with count 37 and simultaneous write -> next cycle count 0, EMPTY=1, ERR_STICKY=0; RST_X low mid-burst -> all outputs at REQ-032 values immediately.
